fetch_queue: RTL and testbench

//   Parametrised instruction fetch queue between icache and dispatch. Generalised in

---
 rtl/fetch_queue.sv | 110 +++++++++++
 tb/tb_fetch_queue.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: buffers icache lines and hands one 32-bit instruction per pop to dispatch, flushing on redirect.
// Define FETCH_QUEUE_STATS_EN to add saturating empty-cycle and redirect counters.
module fetch_queue #(
    parameter logic [31:0] PC_RESET       = 32'h0000_0000,
    parameter int          DEPTH          = 4,
    parameter int          INSTS_PER_LINE = 4,
    localparam int         LINE_W         = 32 * INSTS_PER_LINE
) (
    input  logic              clk,
    input  logic              rst,
    output logic [31:0]       icache_pc_in,
    output logic              icache_rd_en,
    output logic              icache_abort,
    input  logic [LINE_W-1:0] icache_dout,
    input  logic              icache_dout_valid,
    output logic [31:0]       dispatch_pc_out,
    output logic [31:0]       dispatch_inst,
    output logic              dispatch_empty,
    input  logic              dispatch_rd_en,
    input  logic [31:0]       dispatch_jump_branch_address,
    input  logic              dispatch_jump_branch_valid
`ifdef FETCH_QUEUE_STATS_EN
    ,
    output logic [31:0]       stat_empty_cycles,
    output logic [31:0]       stat_redirects
`endif
);
    localparam int          OW         = $clog2(INSTS_PER_LINE);
    localparam int          PW         = $clog2(DEPTH);
    localparam logic [31:0] LINE_BYTES = 32'(4 * INSTS_PER_LINE);
    localparam logic [PW:0] FULL       = (PW + 1)'(DEPTH);

    typedef enum logic {FETCH, HOLD} state_t;

    state_t                             state_q, state_d;
    logic [31:0]                        fetch_pc_q, fetch_pc_d;
    logic [PW:0]                        count_q, count_d;
    logic [PW-1:0]                      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_nxt;
    logic [OW-1:0]                      offset_q, offset_d, wr_start;
    logic [INSTS_PER_LINE-1:0][31:0]    line_q  [DEPTH];
    logic [31:0]                        base_q  [DEPTH];
    logic [OW-1:0]                      start_q [DEPTH];
    logic [31:0]                        wr_base;
    logic                               redir, wr, pop, retire, head_new;

    assign redir           = dispatch_jump_branch_valid;
    assign icache_rd_en    = (state_q == FETCH) && !rst;
    assign icache_abort    = redir && icache_rd_en;
    assign icache_pc_in    = fetch_pc_q;
    assign dispatch_empty  = (count_q == '0);
    assign dispatch_inst   = dispatch_empty ? 32'h0 : line_q[rd_ptr_q][offset_q];
    assign dispatch_pc_out = dispatch_empty ? 32'h0 : base_q[rd_ptr_q] + 32'({offset_q, 2'b00});

    always_comb begin
        wr         = icache_rd_en && icache_dout_valid && !redir;
        pop        = dispatch_rd_en && !dispatch_empty && !redir;
        retire     = pop && (offset_q == '1);
        wr_start   = fetch_pc_q[OW+1:2];
        wr_base    = fetch_pc_q & ~(LINE_BYTES - 32'd1);
        rd_nxt     = rd_ptr_q + PW'(1);
        // the incoming line becomes head when the queue is (or is about to be) empty
        head_new   = retire ? (count_q == (PW + 1)'(1)) : dispatch_empty;
        count_d    = redir ? '0 : count_q + (PW + 1)'(wr) - (PW + 1)'(retire);
        wr_ptr_d   = redir ? '0 : wr_ptr_q + PW'(wr);
        rd_ptr_d   = redir ? '0 : rd_ptr_q + PW'(retire);
        offset_d   = redir ? '0 : head_new ? (wr ? wr_start : '0) : retire ? start_q[rd_nxt] : offset_q + OW'(pop);
        fetch_pc_d = redir ? dispatch_jump_branch_address : wr ? wr_base + LINE_BYTES : fetch_pc_q;
        state_d    = (!redir && count_d == FULL) ? HOLD : FETCH;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= FETCH;
            fetch_pc_q <= PC_RESET;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            offset_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                line_q[i]  <= '0;
                base_q[i]  <= '0;
                start_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            offset_q   <= offset_d;
            if (wr) begin
                line_q[wr_ptr_q]  <= icache_dout;
                base_q[wr_ptr_q]  <= wr_base;
                start_q[wr_ptr_q] <= wr_start;
            end
        end
    end

`ifdef FETCH_QUEUE_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_empty_cycles <= '0;
            stat_redirects    <= '0;
        end else begin
            if (dispatch_empty && stat_empty_cycles != '1) stat_empty_cycles <= stat_empty_cycles + 32'd1;
            if (redir && stat_redirects != '1) stat_redirects <= stat_redirects + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: table vectors, directed corner sequences and random traffic against a word-queue model.
module tb_fetch_queue;
    localparam int DEPTH = 4;
    localparam int IPL   = 4;
    localparam int LW    = 32 * IPL;
    localparam logic [31:0] LB = 32'(4 * IPL);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [31:0]   icache_pc_in;
    logic          icache_rd_en, icache_abort;
    logic [LW-1:0] icache_dout = '0;
    logic          icache_dout_valid = 1'b0;
    logic [31:0]   dispatch_pc_out, dispatch_inst;
    logic          dispatch_empty;
    logic          dispatch_rd_en = 1'b0;
    logic [31:0]   dispatch_jump_branch_address = '0;
    logic          dispatch_jump_branch_valid = 1'b0;
`ifdef FETCH_QUEUE_STATS_EN
    logic [31:0]   stat_empty_cycles, stat_redirects;
`endif

    fetch_queue #(.PC_RESET(32'h0), .DEPTH(DEPTH), .INSTS_PER_LINE(IPL)) dut (
        .clk(clk),
        .rst(rst),
        .icache_pc_in(icache_pc_in),
        .icache_rd_en(icache_rd_en),
        .icache_abort(icache_abort),
        .icache_dout(icache_dout),
        .icache_dout_valid(icache_dout_valid),
        .dispatch_pc_out(dispatch_pc_out),
        .dispatch_inst(dispatch_inst),
        .dispatch_empty(dispatch_empty),
        .dispatch_rd_en(dispatch_rd_en),
        .dispatch_jump_branch_address(dispatch_jump_branch_address),
        .dispatch_jump_branch_valid(dispatch_jump_branch_valid)
`ifdef FETCH_QUEUE_STATS_EN
        ,
        .stat_empty_cycles(stat_empty_cycles),
        .stat_redirects(stat_redirects)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        bit          last;
    } word_t;

    typedef struct {
        logic        rd;
        logic        exp_empty;
        logic [31:0] exp_pc;
        logic [31:0] exp_pcin;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    int          wcnt = 0;
    int          lat = 2;
    bit          rand_lat = 1'b0;
    logic [31:0] ic_pc = '0;
    word_t       mq[$];
    int          m_lines = 0;
    logic [31:0] m_fpc = '0;
    logic [31:0] m_empty = '0;
    logic [31:0] m_redir = '0;
    vec_t        tbl[7];
    logic        r_rd, r_j;
    logic [31:0] r_t;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // icache stand-in: answers the current request after lat cycles with the line at its base
    task automatic respond();
        logic [31:0] b;
        if (icache_rd_en) begin
            if (icache_pc_in != ic_pc) begin
                ic_pc = icache_pc_in;
                wcnt = 0;
            end
            wcnt++;
            icache_dout_valid = (wcnt >= lat);
            if (icache_dout_valid) begin
                wcnt = 0;
                if (rand_lat) lat = $urandom_range(1, 4);
            end
        end else begin
            icache_dout_valid = 1'b0;
            wcnt = 0;
            ic_pc = icache_pc_in;
        end
        b = icache_pc_in & ~(LB - 32'd1);
        for (int i = 0; i < IPL; i++) icache_dout[32*i +: 32] = mem(b + 32'(4 * i));
    endtask

    task automatic check_model();
        logic ren;
        ren = (m_lines < DEPTH);
        chk("empty", dispatch_empty, 32'(mq.size() == 0));
        if (mq.size() == 0) begin
            chk("pc_out", dispatch_pc_out, 32'h0);
            chk("inst", dispatch_inst, 32'h0);
        end else begin
            chk("pc_out", dispatch_pc_out, mq[0].pc);
            chk("inst", dispatch_inst, mq[0].inst);
        end
        chk("rd_en", icache_rd_en, 32'(ren));
        chk("abort", icache_abort, 32'(dispatch_jump_branch_valid && ren));
        if (ren) chk("pc_in", icache_pc_in, m_fpc);
`ifdef FETCH_QUEUE_STATS_EN
        chk("stat_empty", stat_empty_cycles, m_empty);
        chk("stat_redir", stat_redirects, m_redir);
`endif
    endtask

    task automatic update_model();
        bit          acc;
        logic [31:0] b;
        acc = icache_dout_valid && (m_lines < DEPTH) && !dispatch_jump_branch_valid;
        if (mq.size() == 0 && m_empty != 32'hFFFF_FFFF) m_empty++;
        if (dispatch_jump_branch_valid) begin
            if (m_redir != 32'hFFFF_FFFF) m_redir++;
            mq.delete();
            m_lines = 0;
            m_fpc = dispatch_jump_branch_address;
        end else begin
            if (dispatch_rd_en && mq.size() > 0) begin
                if (mq[0].last) m_lines--;
                void'(mq.pop_front());
            end
            if (acc) begin
                b = m_fpc & ~(LB - 32'd1);
                for (int i = int'((m_fpc - b) / 4); i < IPL; i++)
                    mq.push_back('{b + 32'(4 * i), mem(b + 32'(4 * i)), i == IPL - 1});
                m_lines++;
                m_fpc = b + LB;
            end
        end
    endtask

    task automatic drive(input logic rd, input logic jbv, input logic [31:0] tgt);
        dispatch_rd_en = rd;
        dispatch_jump_branch_valid = jbv;
        dispatch_jump_branch_address = tgt;
        respond();
        @(negedge clk);
        check_model();
    endtask

    task automatic commit();
        @(posedge clk);
        update_model();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        dispatch_rd_en = 1'b0;
        dispatch_jump_branch_valid = 1'b0;
        icache_dout_valid = 1'b0;
        #1;
        chk("rst_empty", dispatch_empty, 32'd1);
        chk("rst_rd_en", icache_rd_en, 32'd0);
        chk("rst_abort", icache_abort, 32'd0);
        chk("rst_pc_out", dispatch_pc_out, 32'd0);
        chk("rst_inst", dispatch_inst, 32'd0);
`ifdef FETCH_QUEUE_STATS_EN
        chk("rst_stat_empty", stat_empty_cycles, 32'd0);
        chk("rst_stat_redir", stat_redirects, 32'd0);
`endif
        mq.delete();
        m_lines = 0;
        m_fpc = 32'h0;
        m_empty = '0;
        m_redir = '0;
        wcnt = 0;
        ic_pc = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
    endtask

    initial begin
        tbl[0] = '{1'b1, 1'b1, 32'h00, 32'h00};
        tbl[1] = '{1'b1, 1'b1, 32'h00, 32'h00};
        tbl[2] = '{1'b1, 1'b0, 32'h00, 32'h10};
        tbl[3] = '{1'b1, 1'b0, 32'h04, 32'h10};
        tbl[4] = '{1'b1, 1'b0, 32'h08, 32'h20};
        tbl[5] = '{1'b1, 1'b0, 32'h0C, 32'h20};
        tbl[6] = '{1'b0, 1'b0, 32'h10, 32'h30};

        @(posedge clk);
        #1;
        do_reset();

        lat = 2;
        for (int k = 0; k < 7; k++) begin
            drive(tbl[k].rd, 1'b0, 32'h0);
            chk("t_empty", dispatch_empty, 32'(tbl[k].exp_empty));
            chk("t_pc", dispatch_pc_out, tbl[k].exp_pc);
            chk("t_inst", dispatch_inst, tbl[k].exp_empty ? 32'h0 : mem(tbl[k].exp_pc));
            chk("t_pcin", icache_pc_in, tbl[k].exp_pcin);
            chk("t_rden", icache_rd_en, 32'd1);
            commit();
        end

        lat = 1;
        for (int k = 0; k < 6; k++) begin
            drive(1'b0, 1'b0, 32'h0);
            commit();
        end
        drive(1'b0, 1'b0, 32'h0);
        chk("hold_rd_en", icache_rd_en, 32'd0);
        commit();
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 1'b0, 32'h0);
            chk("hold_pop_pc", dispatch_pc_out, 32'h10 + 32'(4 * k));
            chk("hold_pop_rd_en", icache_rd_en, 32'd0);
            commit();
        end

        lat = 3;
        drive(1'b0, 1'b1, 32'h108);
        chk("resume_rd_en", icache_rd_en, 32'd1);
        chk("resume_pc_in", icache_pc_in, 32'h50);
        chk("redir_abort", icache_abort, 32'd1);
        commit();
        drive(1'b0, 1'b0, 32'h0);
        chk("redir_empty", dispatch_empty, 32'd1);
        chk("redir_pc_in", icache_pc_in, 32'h108);
        commit();
        for (int k = 0; k < 9; k++) begin
            drive(1'b0, 1'b0, 32'h0);
            commit();
        end
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b0, 32'h0);
            chk("mid_pc", dispatch_pc_out, 32'h108 + 32'(4 * k));
            chk("mid_inst", dispatch_inst, mem(32'h108 + 32'(4 * k)));
            commit();
        end

        lat = 1;
        drive(1'b0, 1'b1, 32'h200);
        commit();
        drive(1'b0, 1'b0, 32'h0);
        commit();
        drive(1'b1, 1'b1, 32'h300);
        chk("prio_abort", icache_abort, 32'd1);
        chk("prio_pre_pc", dispatch_pc_out, 32'h200);
        commit();
        drive(1'b0, 1'b0, 32'h0);
        chk("prio_empty", dispatch_empty, 32'd1);
        chk("prio_pc_in", icache_pc_in, 32'h300);
        chk("prio_pc_out", dispatch_pc_out, 32'h0);
        commit();

        drive(1'b0, 1'b1, 32'hFFFF_FFF0);
        commit();
        drive(1'b0, 1'b0, 32'h0);
        chk("wrap_req", icache_pc_in, 32'hFFFF_FFF0);
        commit();
        lat = 6;
        drive(1'b0, 1'b1, 32'h400);
        chk("wrap_pc_in", icache_pc_in, 32'h0);
        chk("wrap_head", dispatch_pc_out, 32'hFFFF_FFF0);
        commit();
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, 1'b0, 32'h0);
            chk("epop_empty", dispatch_empty, 32'd1);
            chk("epop_pc", dispatch_pc_out, 32'h0);
            chk("epop_inst", dispatch_inst, 32'h0);
            chk("epop_pc_in", icache_pc_in, 32'h400);
            chk("epop_rd_en", icache_rd_en, 32'd1);
            commit();
        end

        rand_lat = 1'b1;
        lat = $urandom_range(1, 4);
        for (int n = 0; n < 1500; n++) begin
            r_rd = ($urandom_range(0, 3) < 32'((n / 100) % 4));
            r_j  = ($urandom_range(0, 24) == 0);
            r_t  = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFE0 + ($urandom_range(0, 7) << 2)
                                               : ($urandom & 32'h0000_FFFC);
            drive(r_rd, r_j, r_t);
            commit();
        end

        do_reset();
        rand_lat = 1'b0;
        lat = 1000;
        for (int c = 0; c < 10; c++) begin
            drive(1'b0, (c == 2 || c == 5 || c == 8), 32'h800 + 32'(16 * c));
            commit();
        end
        drive(1'b0, 1'b0, 32'h0);
`ifdef FETCH_QUEUE_STATS_EN
        chk("stat_redir_3", stat_redirects, 32'd3);
        chk("stat_empty_10", stat_empty_cycles, 32'd10);
`endif
        commit();
        do_reset();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
